// File: rtl/div8x4_seq.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN adds div_by_zero and a one-cycle divide-by-zero path.
module div8x4_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dataa,
    input  logic [VW-1:0] datab,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic          div_by_zero
`endif
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient bits shift in at LSB
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   pr_q, pr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;

    logic [VW:0]   pr_shift;
    logic [VW:0]   pr_sub;
    logic [VW:0]   pr_next;
    logic          q_bit;
    logic          fast_zero;

`ifdef DIV_ZERO_FAST_EN
    logic dbz_q, dbz_d;
    assign fast_zero = (dvs_q == '0);
`else
    assign fast_zero = 1'b0;
`endif

    always_comb begin
        pr_shift = {pr_q[VW-1:0], dvd_q[DW-1]};
        pr_sub   = pr_shift - {1'b0, dvs_q};
        q_bit    = (pr_shift >= {1'b0, dvs_q});
        pr_next  = q_bit ? pr_sub : pr_shift;

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_FAST_EN
        dbz_d   = dbz_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dataa;
                    dvs_d   = datab;
                    pr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fast_zero) begin
                    // dvd_q still holds the untouched dividend on the first RUN edge
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = '1;
                    rem_d   = dvd_q[VW-1:0];
`ifdef DIV_ZERO_FAST_EN
                    dbz_d   = 1'b1;
`endif
                end else begin
                    pr_d  = pr_next;
                    dvd_d = {dvd_q[DW-2:0], q_bit};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        quot_d  = {dvd_q[DW-2:0], q_bit};
                        rem_d   = pr_next[VW-1:0];
`ifdef DIV_ZERO_FAST_EN
                        dbz_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_FAST_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_ZERO_FAST_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_FAST_EN
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_div8x4_seq.sv
// Directed bench for div8x4_seq: vector table plus back-to-back, start-while-busy and mid-run reset sequences.
module tb_div8x4_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dataa;
    logic [3:0] datab;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
`ifdef DIV_ZERO_FAST_EN
    logic       div_by_zero;
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 8;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div8x4_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef DIV_ZERO_FAST_EN
        .remainder (remainder),
        .div_by_zero(div_by_zero)
`else
        .remainder (remainder)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Issue one start and wait for done; returns at the negedge of the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; dataa = a; datab = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: done not seen for %0d/%0d", a, b);
        end
    endtask

    initial begin
        int lat, bcnt, n, dcount;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  8};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  8};
        vecs[2] = '{8'd0,   4'd5,  8'd0,   4'd0,  8};
        vecs[3] = '{8'd14,  4'd15, 8'd0,   4'd14, 8};
        vecs[4] = '{8'd13,  4'd0,  8'hFF,  4'hD,  ZLAT};
        vecs[5] = '{8'd100, 4'd3,  8'd33,  4'd1,  8};
        vecs[6] = '{8'd143, 4'd11, 8'd13,  4'd0,  8};
        vecs[7] = '{8'd250, 4'd4,  8'd62,  4'd2,  8};
        vecs[8] = '{8'd255, 4'd1,  8'd255, 4'd0,  8};

        reset = 1'b1; start = 1'b0; dataa = '0; datab = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
`ifdef DIV_ZERO_FAST_EN
        check("reset_dbz", int'(div_by_zero), 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt);
            $display("[TB] vec %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", i, vecs[i].a, vecs[i].b,
                     quotient, remainder, lat);
            check($sformatf("v%0d_quotient", i), int'(quotient), int'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), int'(remainder), int'(vecs[i].r));
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
            check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
`ifdef DIV_ZERO_FAST_EN
            check($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(vecs[i].b == 4'd0));
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_pulse_end", i), int'(done), 0);
            check($sformatf("v%0d_quotient_held", i), int'(quotient), int'(vecs[i].q));
        end

        // Back-to-back: second start in the done cycle of the first
        run_op(8'd200, 4'd7, lat, bcnt);
        check("b2b_first_quotient", int'(quotient), 28);
        start = 1'b1; dataa = 8'd100; datab = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_after_accept", int'(busy), 1);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        $display("[TB] b2b: second done %0d cycles after first, q=%0d r=%0d", n, quotient, remainder);
        check("b2b_gap", n, 9);
        check("b2b_quotient", int'(quotient), 33);
        check("b2b_remainder", int'(remainder), 1);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        start = 1'b1; dataa = 8'd200; datab = 4'd7;
        @(negedge clk);
        dcount = 0;
        for (int k = 0; k < 24; k++) begin
            if (done) dcount++;
            if (busy) begin
                start = 1'b1; dataa = 8'(k * 37 + 5); datab = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                check("ignore_quotient", int'(quotient), 28);
                check("ignore_remainder", int'(remainder), 4);
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("[TB] start-while-busy: %0d done pulses", dcount);
        check("ignore_done_count", dcount, 1);

        // Reset asserted at RUN iteration 4
        @(negedge clk);
        start = 1'b1; dataa = 8'd90; datab = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        $display("[TB] mid-run reset: %0d done pulses afterwards", dcount);
        check("midrst_no_done", dcount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div8x4_seq.md
Name: div8x4_seq

Overview:
- Sequential restoring divider; the inverse operation of the team's 4x4 combinational multiplier and a companion to the 8x8 multiplier datapath.
- Takes an 8-bit dividend and a 4-bit divisor.
- Returns an 8-bit quotient and a 4-bit remainder after a fixed 8-cycle iteration, one quotient bit per clock.
- Used wherever a product must be split back into factors, e.g. self-checking the multiplier output.

Parameters:
- DW, 8, dividend and quotient width (bits); one iteration per bit.
- VW, 4, divisor and remainder width (bits); VW < DW required.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only while busy=0
- dataa  input  DW  dividend, captured on the accepting edge
- datab  input  VW  divisor, captured on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse, results valid
- quotient  output  DW  registered quotient
- remainder  output  VW  registered remainder
- div_by_zero  output  1  only present when DIV_ZERO_FAST_EN is defined

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - busy=0, done=0, quotient=0, remainder=0 (div_by_zero=0 if present).
  - FSM=IDLE, iteration counter=0, internal shift registers=0.
- FSM states: IDLE, RUN. DONE is not a separate state; done is a registered pulse.
- IDLE:
  - On an edge with start=1: capture dataa/datab, clear the partial remainder (VW+1 bits), counter=0, busy=1, go to RUN.
  - start=0: hold.
- RUN, one iteration per edge, MSB first:
  - pr = {pr[VW-1:0], next dividend bit}.
  - If pr >= {0,divisor}: pr -= divisor and quotient bit = 1; else quotient bit = 0.
  - Counter increments on every RUN edge.
- Completion, on the DW-th RUN edge:
  - Load quotient/remainder outputs, done=1, busy=0, go to IDLE.
  - done clears on the next edge unless a new completion occurs.
- Latency: start accepted at edge N; busy high after edges N..N+DW-1; done high after edge N+DW (default N+8) for exactly one cycle.
- start while busy=1 is ignored (no queueing); dataa/datab changes during RUN have no effect.
- start in the same cycle that done=1 (FSM is in IDLE) is accepted, which gives back-to-back operation with throughput of 1 result per DW+1 cycles.
- quotient/remainder hold their last result until the next completion; they are not cleared on start.
- Divide by zero (no macro):
  - Runs the normal DW iterations.
  - Result is quotient = all ones (8'hFF) and remainder = dataa[VW-1:0]; this is the natural restoring result.
- Arithmetic: unsigned only; invariant dataa == quotient*datab + remainder and remainder < datab for datab != 0.
- Reset asserted mid-RUN: the operation is aborted at that edge, all outputs return to reset values, and no done pulse is issued.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - Adds the div_by_zero output.
  - If the captured datab == 0, RUN is skipped: done=1 on edge N+1 with quotient=8'hFF, remainder=dataa[VW-1:0], div_by_zero=1.
  - div_by_zero is held with the result and cleared by the next completion with datab != 0, or by reset.
- Undefined: no div_by_zero port; divide by zero takes the full DW-cycle latency with the same data result.

Test Plan:
- reset=1 for 2 cycles, then start=1 with dataa=200, datab=7 -> done exactly 8 cycles after the accepting edge, quotient=28, remainder=4, busy high for 8 cycles.
- dataa=255, datab=15 -> quotient=17, remainder=0; then dataa=0, datab=5 -> quotient=0, remainder=0; then dataa=14, datab=15 -> quotient=0, remainder=14.
- Back-to-back: second start (dataa=100, datab=3) asserted in the done cycle of the first -> accepted; quotient=33, remainder=1 exactly 9 cycles after the first done.
- start pulsed every cycle during RUN with varying dataa -> ignored; the first result is unchanged and only one done pulse is produced.
- dataa=13, datab=0 -> quotient=8'hFF, remainder=4'hD. Without the macro this arrives after 8 cycles; with DIV_ZERO_FAST_EN it arrives after 1 cycle with div_by_zero=1.
- reset asserted at RUN iteration 4 (dataa=90, datab=9) -> next edge shows busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
